// File: rtl/max_pool_2x2.sv
`default_nettype none
// ============================================================================
// max_pool_2x2 : streaming 2x2 / stride-2 max pooling over a raster feature map
// Revision 1.0
// ============================================================================
module max_pool_2x2 #(
  parameter int data_width = 20,
  parameter int img_width  = 8,
  parameter int img_height = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  output logic                  frame_done
);

  localparam int c_col_w   = (img_width  > 2) ? $clog2(img_width)  : 1;
  localparam int c_row_w   = (img_height > 2) ? $clog2(img_height) : 1;
  localparam int c_half_w  = img_width / 2;
  localparam int c_idx_w   = (c_half_w > 1) ? $clog2(c_half_w) : 1;

  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(img_width - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(img_height - 1);

  generate
    if ((img_width % 2 != 0) || (img_width < 2) ||
        (img_height % 2 != 0) || (img_height < 2)) begin : g_bad_geometry
      $error("max_pool_2x2: img_width and img_height must be even and >= 2");
    end
  endgenerate

  logic [c_col_w-1:0]    col;
  logic [c_row_w-1:0]    row;
  logic [data_width-1:0] hold_px;
  logic [data_width-1:0] line_buf [0:c_half_w-1];

  logic [c_idx_w-1:0]    buf_idx;
  logic [data_width-1:0] pair_max;
  logic [data_width-1:0] buf_px;
  logic [data_width-1:0] win_max;
  logic                  col_is_last;
  logic                  row_is_last;

  always_comb begin
    buf_idx     = c_idx_w'(col >> 1);
    pair_max    = (in_data > hold_px) ? in_data : hold_px;
    buf_px      = line_buf[buf_idx];
    win_max     = (buf_px > pair_max) ? buf_px : pair_max;
    col_is_last = (col == c_col_last);
    row_is_last = (row == c_row_last);
  end

  // Every entry is rewritten on each even row before the odd row reads it,
  // so the buffer never needs clearing.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && col[0] && !row[0]) begin
      line_buf[buf_idx] <= pair_max;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      hold_px    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (!col[0]) begin
          hold_px <= in_data;
        end else if (row[0]) begin
          out_valid  <= 1'b1;
          out_data   <= win_max;
          frame_done <= row_is_last && col_is_last;
        end

        if (col_is_last) begin
          col <= '0;
          row <= row_is_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
`default_nettype none
// ============================================================================
// tb_max_pool_2x2 : directed self-checking bench for max_pool_2x2 on a 4x4 map
// Revision 1.0
// ============================================================================
module tb_max_pool_2x2;

  localparam int DW = 20;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          frame_done;

  int total;
  int bad;
  logic [DW-1:0] last_out;

  max_pool_2x2 #(.data_width(DW), .img_width(4), .img_height(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one input cycle and settle just after the sampling edge.
  task automatic step(input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // In a 4x4 raster, pixel k completes a window when col and row are both odd.
  function automatic bit completes(input int k);
    return (k % 2 == 1) && ((k / 4) % 2 == 1);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 20'd77;
    #1;
    total++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_async: valid=%b done=%b data=%h required 0/0/0",
               out_valid, frame_done, out_data);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_hold: valid=%b data=%h required 0/0", out_valid, out_data);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    last_out = '0;
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_q [4] = '{20'd5, 20'd7, 20'd13, 20'd15};
    int n = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, DW'(k));
      if (completes(k)) last_out = exp_q[n++];
      total++;
      if (out_valid !== completes(k) || out_data !== last_out || frame_done !== (k == 15)) begin
        bad++;
        $display("FAIL stream px%0d: valid=%b data=%0d done=%b required %b/%0d/%b",
                 k, out_valid, out_data, frame_done, completes(k), last_out, k == 15);
      end
    end
  endtask

  task automatic test_gapped();
    logic [DW-1:0] exp_q [4] = '{20'd5, 20'd7, 20'd13, 20'd15};
    int n = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, DW'(k));
      if (completes(k)) last_out = exp_q[n++];
      total++;
      if (out_valid !== completes(k) || out_data !== last_out || frame_done !== (k == 15)) begin
        bad++;
        $display("FAIL gapped px%0d: valid=%b data=%0d done=%b required %b/%0d/%b",
                 k, out_valid, out_data, frame_done, completes(k), last_out, k == 15);
      end
      step(1'b0, 20'hABCDE);
      total++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_data !== last_out) begin
        bad++;
        $display("FAIL gapped_idle px%0d: valid=%b done=%b data=%0d required 0/0/%0d",
                 k, out_valid, frame_done, out_data, last_out);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [DW-1:0] px [16] = '{20'hFFFFF, 20'h0,  20'd2, 20'd3,
                               20'h80000, 20'h1,  20'd4, 20'd5,
                               20'd9,     20'd8,  20'd7, 20'd6,
                               20'd1,     20'd2,  20'd3, 20'd4};
    logic [DW-1:0] exp_q [4] = '{20'hFFFFF, 20'd5, 20'd9, 20'd7};
    int n = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, px[k]);
      if (completes(k)) last_out = exp_q[n++];
      total++;
      if (out_valid !== completes(k) || out_data !== last_out || frame_done !== (k == 15)) begin
        bad++;
        $display("FAIL unsigned px%0d: valid=%b data=%h done=%b required %b/%h/%b",
                 k, out_valid, out_data, frame_done, completes(k), last_out, k == 15);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    for (int k = 0; k < 32; k++) begin
      step(1'b1, (k < 16) ? 20'd100 : 20'd3);
      if (completes(k % 16)) last_out = (k < 16) ? 20'd100 : 20'd3;
      if (frame_done === 1'b1) dones++;
      total++;
      if (out_valid !== completes(k % 16) || out_data !== last_out) begin
        bad++;
        $display("FAIL b2b px%0d: valid=%b data=%0d required %b/%0d",
                 k, out_valid, out_data, completes(k % 16), last_out);
      end
    end
    total++;
    if (dones !== 2) begin
      bad++;
      $display("FAIL b2b_frame_done: pulses=%0d required 2", dones);
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] exp_q [4] = '{20'd5, 20'd7, 20'd13, 20'd15};
    int n = 0;
    int outs = 0;
    for (int k = 0; k < 6; k++) step(1'b1, DW'(500 + k));
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 20'd999;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL midrst_clear: valid=%b data=%0d required 0/0", out_valid, out_data);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    last_out = '0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, DW'(k));
      if (completes(k)) last_out = exp_q[n++];
      if (out_valid === 1'b1) outs++;
      total++;
      if (out_valid !== completes(k) || out_data !== last_out || frame_done !== (k == 15)) begin
        bad++;
        $display("FAIL midrst px%0d: valid=%b data=%0d done=%b required %b/%0d/%b",
                 k, out_valid, out_data, frame_done, completes(k), last_out, k == 15);
      end
    end
    total++;
    if (outs !== 4) begin
      bad++;
      $display("FAIL midrst_count: outputs=%0d required 4", outs);
    end
  endtask

  task automatic test_zero();
    int outs = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 20'd0);
      if (out_valid === 1'b1) outs++;
      if (completes(k)) last_out = 20'd0;
      total++;
      if (out_valid !== completes(k) || out_data !== last_out) begin
        bad++;
        $display("FAIL zero px%0d: valid=%b data=%0d required %b/%0d",
                 k, out_valid, out_data, completes(k), last_out);
      end
    end
    total++;
    if (outs !== 4) begin
      bad++;
      $display("FAIL zero_count: outputs=%0d required 4", outs);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    last_out = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    test_stream();
    test_reset();
    test_gapped();
    test_unsigned();
    test_back_to_back();
    test_mid_reset();
    test_zero();

    step(1'b0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001: Parameter data_width, default 20, bit width of every pixel in and out; it matches the upstream RELU output width.
REQ-002: Parameter img_width, default 8, input feature-map columns; it SHALL be even and at least 2.
REQ-003: Parameter img_height, default 8, input feature-map rows; it SHALL be even and at least 2.
REQ-004: clk  input  1  single clock; all state updates on the rising edge.
REQ-005: rst  input  1  asynchronous, active-high reset.
REQ-006: in_valid  input  1  in_data carries one pixel this cycle.
REQ-007: in_data  input  data_width  unsigned post-ReLU pixel, raster order (row-major, left to right).
REQ-008: out_valid  output  1  out_data holds one pooled pixel this cycle.
REQ-009: out_data  output  data_width  unsigned maximum of one 2x2 window.
REQ-010: frame_done  output  1  one-cycle pulse when the last pooled pixel of a frame is emitted.

Function
REQ-011: The block SHALL perform 2x2 max pooling with stride 2 and produce (img_width/2)*(img_height/2) outputs per frame.
REQ-012: The block SHALL provide no backpressure; every cycle with in_valid=1 consumes exactly one pixel, and cycles with in_valid=0 leave all state unchanged.
REQ-013: Internal counters SHALL be a column counter col (0..img_width-1) and a row counter row (0..img_height-1), advanced only on accepted pixels.
REQ-014: A pixel accepted at even col SHALL be held in a register, hold_px.
REQ-015: At odd col, the block SHALL form pair_max = max(hold_px, in_data).
REQ-016: At odd col on an even row, pair_max SHALL be written to line_buf[col>>1], a buffer of img_width/2 entries.
REQ-017: At odd col on an odd row, out_data SHALL be max(line_buf[col>>1], pair_max), and out_valid SHALL be high on the next rising edge (latency 1 cycle from the completing pixel).
REQ-018: out_valid SHALL be high for exactly one cycle per pooled pixel; out_data SHALL hold its last value while out_valid is low.
REQ-019: Comparisons SHALL be unsigned over the full data_width bits; equal values yield that value; no saturation or truncation occurs.
REQ-020: When col=img_width-1 is accepted, col SHALL wrap to 0 and row SHALL increment.
REQ-021: When row=img_height-1 and col=img_width-1 are accepted together, row SHALL wrap to 0, and frame_done SHALL pulse in the same cycle as that final out_valid.
REQ-022: A new frame SHALL be accepted on the cycle immediately after the last pixel of the previous frame, with no idle cycle.
REQ-023: line_buf entries SHALL be overwritten each even row; stale contents from a previous frame SHALL never reach out_data.

Reset
REQ-024: While rst=1, col, row, out_valid and frame_done SHALL be 0, and out_data and hold_px SHALL be 0, asynchronously.
REQ-025: line_buf SHALL not require reset, per REQ-023.
REQ-026: Reset asserted mid-frame SHALL discard the partial frame; the first pixel accepted after deassertion SHALL be treated as row 0, col 0.
REQ-027: in_valid SHALL be ignored during any cycle with rst=1.

Verification
REQ-028: 4x4 frame (img_width=img_height=4) with pixels 0..15 streamed back-to-back -> outputs 5, 7, 13, 15 in that order, each one cycle after pixels 5, 7, 13, 15; frame_done pulses with 15.
REQ-029: Same 4x4 frame with in_valid toggling 1,0,1,0 -> identical output values, each 1 cycle after its completing pixel; no extra out_valid pulses.
REQ-030: Window holding 20'hFFFFF, 0, 20'h80000, 1 -> out_data = 20'hFFFFF, confirming unsigned full-width compare.
REQ-031: Two 4x4 frames back-to-back, frame 1 all 100 and frame 2 all 3 -> frame 2 outputs are all 3 and frame_done pulses twice.
REQ-032: rst pulsed after 6 pixels of a frame, then a full 4x4 frame streamed -> exactly 4 outputs, all correct, and no output derived from pre-reset pixels.
REQ-033: All-zero frame (ReLU-clamped input) -> four outputs of 0 with out_valid asserted each time.
